// File: rtl/common.sv
// Shared pipeline types: write-back source selection carried from decode to retire.
package common;

  typedef enum logic [2:0] {
    RI_TYPE_LUI = 3'd0,
    LOAD        = 3'd1,
    JUMP        = 3'd2,
    ZICSR       = 3'd3,
    WB_MRET     = 3'd4,
    WB_NONE     = 3'd5
  } wb_sel_t;

endpackage

// File: rtl/wb_retire_queue.sv
// In-order write-back/retire queue: buffers executed instructions, merges returning load
// data with sub-word extraction, and retires one entry per cycle onto a registered RF port.
module wb_retire_queue
  import common::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1),
  parameter int unsigned OFS_W = $clog2(XLEN / 8)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  wb_sel_t            in_wb_sel,
  input  logic [4:0]         in_rd,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic [XLEN-1:0]    in_pc_plus_4,
  input  logic [XLEN-1:0]    in_csr_data,
  input  logic [1:0]         in_ld_size,
  input  logic               in_ld_unsigned,
  input  logic [OFS_W-1:0]   in_addr_lo,
  input  logic               rsp_valid,
  input  logic [XLEN-1:0]    rsp_data,
  output logic               rf_we,
  output logic [4:0]         rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               retire,
  output logic [CNT_W-1:0]   count,
  output logic               rsp_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic             we;
    logic [4:0]       rd;
    logic             is_load;
    logic [1:0]       size;
    logic             uns;
    logic [OFS_W-1:0] ofs;
    logic [XLEN-1:0]  data;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic             retire_q, retire_d;
  logic             rsp_err_q, rsp_err_d;

  entry_t           head;
  entry_t           new_ent;
  logic             empty;
  logic             push;
  logic             pop;
  logic [OFS_W-1:0] ld_ofs;
  logic [XLEN-1:0]  ld_shift;
  logic [XLEN-1:0]  ld_mask;
  logic             ld_sign;
  logic [XLEN-1:0]  ld_val;

  // Build the entry to enqueue; non-load results are resolved here so retire only muxes loads.
  always_comb begin
    new_ent         = '0;
    new_ent.rd      = in_rd;
    new_ent.size    = in_ld_size;
    new_ent.uns     = in_ld_unsigned;
    new_ent.ofs     = in_addr_lo;
    case (in_wb_sel)
      RI_TYPE_LUI: begin new_ent.data = in_alu_result; new_ent.we = 1'b1; end
      LOAD:        begin new_ent.is_load = 1'b1;       new_ent.we = 1'b1; end
      JUMP:        begin new_ent.data = in_pc_plus_4;  new_ent.we = 1'b1; end
      ZICSR:       begin new_ent.data = in_csr_data;   new_ent.we = 1'b1; end
      default:     new_ent.we = 1'b0;
    endcase
    new_ent.we = new_ent.we && (in_rd != 5'd0);
  end

  // Sub-word load extraction: align the lane down to the access size, shift, then extend.
  always_comb begin
    ld_ofs  = head.ofs;
    ld_mask = XLEN'(32'hFFFF_FFFF);
    case (head.size)
      2'd0: begin
        ld_ofs  = head.ofs;
        ld_mask = XLEN'(32'h0000_00FF);
      end
      2'd1: begin
        ld_ofs  = head.ofs & ~OFS_W'(1);
        ld_mask = XLEN'(32'h0000_FFFF);
      end
      default: begin
        ld_ofs  = head.ofs & ~OFS_W'(3);
        ld_mask = XLEN'(32'hFFFF_FFFF);
      end
    endcase
    ld_shift = rsp_data >> {ld_ofs, 3'b000};
    case (head.size)
      2'd0:    ld_sign = ld_shift[7];
      2'd1:    ld_sign = ld_shift[15];
      default: ld_sign = ld_shift[31];
    endcase
    ld_val = ld_shift & ld_mask;
    if (!head.uns && ld_sign) begin
      ld_val = ld_val | ~ld_mask;
    end
  end

  always_comb begin
    head  = ent_q[rd_ptr_q];
    empty = (count_q == '0);
    push  = in_valid && in_ready_q;
    pop   = !empty && (!head.is_load || rsp_valid);

    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_d[i] = ent_q[i];
    end
    if (push) begin
      ent_d[wr_ptr_q] = new_ent;
    end

    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    in_ready_d = (count_d != CNT_W'(DEPTH));

    rf_we_d    = pop && head.we;
    rf_waddr_d = pop ? head.rd : 5'd0;
    rf_wdata_d = '0;
    if (pop) begin
      rf_wdata_d = head.is_load ? ld_val : head.data;
    end
    retire_d   = pop;
    // A response with no LOAD waiting at the head has nowhere to go.
    rsp_err_d  = rsp_err_q || (rsp_valid && (empty || !head.is_load));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
      retire_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= ent_d[i];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      retire_q   <= retire_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign in_ready = in_ready_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign retire   = retire_q;
  assign count    = count_q;
  assign rsp_err  = rsp_err_q;

endmodule
